gate_test_seq: RTL and testbench

GATE_TEST_SEQ -- requirements
Module: gate_test_seq

---
 rtl/gate_test_seq_pkg.sv | 26 ++
 rtl/gate_ref_model.sv | 28 ++
 rtl/gate_test_seq.sv | 107 ++++++++++
 tb/tb_gate_test_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_seq_pkg.sv
// Shared types and defaults for the gate test sequencer.
`default_nettype none

package gate_test_seq_pkg;

  typedef enum logic [1:0] {
    GATE_NOT = 2'd0,
    GATE_AND = 2'd1,
    GATE_OR  = 2'd2,
    GATE_XOR = 2'd3
  } gate_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_N_IN   = 2;
  localparam int DEF_SETTLE = 4;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// Combinational golden model: expected gate response for a stimulus vector.
`default_nettype none

module gate_ref_model
  import gate_test_seq_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) (
  input  gate_sel_e         gate_sel,
  input  logic [N_IN-1:0]   vector,
  output logic              expected
);

  always_comb begin
    expected = 1'b0;
    case (gate_sel)
      // NOT only looks at bit 0; upper bits are still swept by the sequencer
      GATE_NOT: expected = ~vector[0];
      GATE_AND: expected = &vector;
      GATE_OR:  expected = |vector;
      GATE_XOR: expected = ^vector;
      default:  expected = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_test_seq.sv
// Exhaustive gate tester: sweeps every input vector, waits SETTLE cycles,
// compares the gate response to a reference model and reports the result.
`default_nettype none

module gate_test_seq
  import gate_test_seq_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      gate_sel,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  state_e          state;
  gate_sel_e       sel;
  logic [N_IN-1:0] vector;
  logic [7:0]      cnt;
  logic            seen_fail;
  logic            expected;
  logic            mismatch;

  gate_ref_model #(.N_IN(N_IN)) u_ref (
    .gate_sel (sel),
    .vector   (vector),
    .expected (expected)
  );

  assign mismatch = (dut_out != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sel       <= GATE_NOT;
      vector    <= '0;
      cnt       <= '0;
      seen_fail <= 1'b0;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_APPLY;
            sel       <= gate_sel_e'(gate_sel);
            vector    <= '0;
            dut_in    <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
            seen_fail <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_APPLY: begin
          cnt   <= 8'(SETTLE);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // leave on the edge where the counter hits zero: SETTLE cycles here
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + (N_IN+1)'(1);
            if (!seen_fail) begin
              fail_vec  <= vector;
              seen_fail <= 1'b1;
            end
          end
          if (vector == '1) begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            vector <= vector + N_IN'(1);
            dut_in <= vector + N_IN'(1);
            state  <= ST_APPLY;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_test_seq.sv
// Directed bench for gate_test_seq: four parameterisations driven by behavioural gates.
`default_nettype none

module tb_gate_test_seq;
  import gate_test_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] gate_sel;
  logic [3:0] start_v;
  int         model_sel;

  // u1: N_IN=1 SETTLE=4, ideal NOT
  logic [0:0] in1;  logic out1, busy1, done1, pass1; logic [1:0] err1; logic [0:0] fv1;
  // u2: N_IN=2 SETTLE=4, selectable behavioural gate
  logic [1:0] in2;  logic out2, busy2, done2, pass2; logic [2:0] err2; logic [1:0] fv2;
  // u3: N_IN=1 SETTLE=2, NOT with a 10-cycle delay line
  logic [0:0] in3;  logic out3, busy3, done3, pass3; logic [1:0] err3; logic [0:0] fv3;
  // u4: N_IN=3 SETTLE=1, ideal XOR
  logic [2:0] in4;  logic out4, busy4, done4, pass4; logic [3:0] err4; logic [2:0] fv4;

  logic [9:0] dly;
  logic [3:0] done_v;
  assign done_v = {done4, done3, done2, done1};

  assign out1 = ~in1[0];
  assign out4 = ^in4;
  assign out3 = dly[9];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) dly <= '0;
    else        dly <= {dly[8:0], ~in3[0]};

  always_comb begin
    out2 = 1'b0;
    case (model_sel)
      0: out2 = |in2;
      1: out2 = &in2;
      2: out2 = ^in2;
      3: out2 = ~in2[0];
      4: out2 = ~&in2;
      default: out2 = 1'b0;
    endcase
  end

  gate_test_seq #(.N_IN(1), .SETTLE(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_sel(gate_sel), .dut_in(in1),
    .dut_out(out1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));
  gate_test_seq #(.N_IN(2), .SETTLE(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_sel(gate_sel), .dut_in(in2),
    .dut_out(out2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2));
  gate_test_seq #(.N_IN(1), .SETTLE(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .gate_sel(gate_sel), .dut_in(in3),
    .dut_out(out3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3));
  gate_test_seq #(.N_IN(3), .SETTLE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .gate_sel(gate_sel), .dut_in(in4),
    .dut_out(out4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4), .fail_vec(fv4));

  int errors = 0;
  int checks = 0;
  logic [2:0] seen [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Accept a start on instance w, then count cycles until its done pulse.
  // abuse re-pulses start and flips gate_sel mid-run; both must be ignored.
  task automatic run(input int w, input logic [1:0] sel, input bit abuse, output int cyc);
    gate_sel   = sel;
    start_v[w] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    cyc = -1;
    if (w == 3) seen[0] = in4;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (abuse && k == 5) begin
        start_v[w] = 1'b1;
        gate_sel   = sel ^ 2'b11;
      end
      if (abuse && k == 6) start_v[w] = 1'b0;
      if (w == 3 && k % 3 == 0 && k / 3 < 8) seen[k/3] = in4;
      if (done_v[w]) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic u2_result(input string tag, input int cyc, input int p, input int e, input int f);
    check({tag, " cycle"}, cyc, 24);
    check({tag, " pass"}, pass2, p);
    check({tag, " err"}, err2, e);
    check({tag, " fail_vec"}, fv2, f);
    @(posedge clk); #1;
    check({tag, " done width"}, done2, 0);
    check({tag, " idle"}, busy2, 0);
  endtask

  initial begin
    int  cyc;
    bit  saw_done;
    rst_n     = 1'b0;
    start_v   = '0;
    gate_sel  = 2'd0;
    model_sel = 0;
    #23;
    check("rst busy", busy2, 0);
    check("rst done", done2, 0);
    check("rst pass", pass2, 0);
    check("rst err", err2, 0);
    check("rst fail_vec", fv2, 0);
    check("rst dut_in", in2, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1-input ideal NOT
    run(0, GATE_NOT, 0, cyc);
    check("not1 cycle", cyc, 12);
    check("not1 pass", pass1, 1);
    check("not1 err", err1, 0);
    check("not1 fail_vec", fv1, 0);
    @(posedge clk); #1;
    check("not1 done width", done1, 0);
    repeat (3) @(posedge clk); #1;
    check("not1 pass hold", pass1, 1);

    // AND expected, OR gate fitted: vectors 01 and 10 miss
    model_sel = 0;
    run(1, GATE_AND, 0, cyc);
    u2_result("and_vs_or", cyc, 0, 2, 1);
    repeat (3) @(posedge clk); #1;
    check("and_vs_or err hold", err2, 2);
    check("and_vs_or fv hold", fv2, 1);

    run(1, GATE_AND, 1, cyc);
    u2_result("abuse", cyc, 0, 2, 1);

    // XOR expected, AND gate fitted: 01, 10, 11 miss
    model_sel = 1;
    run(1, GATE_XOR, 0, cyc);
    u2_result("xor_vs_and", cyc, 0, 3, 1);

    model_sel = 3;
    run(1, GATE_NOT, 0, cyc);
    u2_result("not2", cyc, 1, 0, 0);

    model_sel = 0;
    run(1, GATE_OR, 0, cyc);
    u2_result("or2", cyc, 1, 0, 0);

    // every vector wrong: count reaches 2^N_IN without wrapping
    model_sel = 4;
    run(1, GATE_AND, 0, cyc);
    u2_result("and_vs_nand", cyc, 0, 4, 0);

    // reset at cycle 10 of a run
    model_sel = 0;
    gate_sel  = GATE_AND;
    start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v = '0;
    repeat (10) @(posedge clk);
    #1;
    check("mid busy", busy2, 1);
    check("mid dut_in", in2, 1);
    rst_n = 1'b0;
    #1;
    check("arst busy", busy2, 0);
    check("arst dut_in", in2, 0);
    check("arst err", err2, 0);
    check("arst fail_vec", fv2, 0);
    check("arst pass", pass2, 0);
    check("arst done", done2, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done2 || busy2) saw_done = 1;
    end
    check("post rst quiet", saw_done, 0);
    run(1, GATE_AND, 0, cyc);
    u2_result("after_rst", cyc, 0, 2, 1);

    // delayed NOT: start accepted on the 4th edge after reset release
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(2, GATE_NOT, 0, cyc);
    check("slow_not cycle", cyc, 8);
    check("slow_not pass", pass3, 0);
    check("slow_not err", err3, 2);
    check("slow_not fail_vec", fv3, 0);

    // 3-input XOR, SETTLE=1
    run(3, GATE_XOR, 0, cyc);
    check("xor3 cycle", cyc, 24);
    check("xor3 pass", pass4, 1);
    check("xor3 err", err4, 0);
    for (int i = 0; i < 8; i++) check($sformatf("xor3 sweep %0d", i), seen[i], i);
    repeat (2) @(posedge clk); #1;
    check("xor3 dut_in hold", in4, 7);
    check("xor3 idle", busy4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
